// File: rtl/bucket_pkg.sv
// Shared types and constants for the log2-bucket decoder and the monitors built on it.
package bucket_pkg;

  localparam int CODE_W   = 4;
  localparam int VAL_W    = 10;
  localparam int MAX_CODE = 9;

  typedef struct packed {
    logic             err;
    logic [VAL_W-1:0] hi;
    logic [VAL_W-1:0] lo;
  } bucket_range_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/bucket_decoder_if.sv
// Code-in / range-out handshake bundle of the bucket decoder.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds its payload stable while valid is high and ready is low.
interface bucket_decoder_if #(
  parameter int ERR_CNT_W = 8
) ();
  import bucket_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [CODE_W-1:0]    in_code;
  logic                 out_valid;
  logic                 out_ready;
  logic [VAL_W-1:0]     out_lo;
  logic [VAL_W-1:0]     out_hi;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_err, err_count
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_err, err_count
  );
endinterface

// File: rtl/bucket_decoder_lut.sv
// Combinational bucket code -> inclusive value range table; codes above MAX_CODE flag err.
module bucket_lut
  import bucket_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output bucket_range_t     range
);

  logic [VAL_W-1:0] pow;

  always_comb begin
    pow   = VAL_W'(1) << code;
    range = '0;
    if (code == CODE_W'(0)) begin
      range.lo = '0;
      range.hi = '0;
    end else if (code == CODE_W'(1)) begin
      range.lo = VAL_W'(1);
      range.hi = VAL_W'(3);
    end else if (code <= CODE_W'(MAX_CODE)) begin
      // 2**(k+1)-1 is the power of two with every lower bit set.
      range.lo = pow;
      range.hi = pow | (pow - VAL_W'(1));
    end else begin
      range.err = 1'b1;
    end
  end

endmodule

// File: rtl/bucket_decoder.sv
// Bucket decoder: decodes accepted codes into ranges, buffers them in a small FIFO,
// and counts illegal codes with a saturating counter.
module bucket_decoder
  import bucket_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic             c,
  input  logic             rst,
  bucket_decoder_if.slave  bus,
  output fifo_state_e      dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  bucket_range_t        mem [DEPTH];
  bucket_range_t        dec;
  bucket_range_t        head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_d;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 push, pop;
  fifo_state_e          state_q, state_d;

  bucket_lut u_lut (
    .code  (bus.in_code),
    .range (dec)
  );

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge c) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      if (push && dec.err && (err_q != '1)) err_q <= err_q + ERR_CNT_W'(1);
    end
  end

  // FIFO occupancy FSM: state register.
  always_ff @(posedge c) begin
    if (rst) state_q <= FIFO_EMPTY;
    else     state_q <= state_d;
  end

  // Next state follows the post-transfer occupancy.
  always_comb begin
    state_d = state_q;
    if (push != pop) begin
      if (count_d == '0)                state_d = FIFO_EMPTY;
      else if (count_d == CNT_W'(DEPTH)) state_d = FIFO_FULL;
      else                              state_d = FIFO_PARTIAL;
    end
  end

  // Outputs: no full-bypass, so in_ready depends only on registered state.
  always_comb begin
    head          = mem[rd_ptr];
    bus.in_ready  = !rst && (state_q != FIFO_FULL);
    bus.out_valid = !rst && (state_q != FIFO_EMPTY);
    bus.out_lo    = bus.out_valid ? head.lo  : '0;
    bus.out_hi    = bus.out_valid ? head.hi  : '0;
    bus.out_err   = bus.out_valid ? head.err : 1'b0;
    bus.err_count = err_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_bucket_decoder.sv
// Self-checking bench for bucket_decoder: vector table, handshake corner sequences,
// and a scoreboard tracking every accepted code through to its pop.
module tb_bucket_decoder;
  import bucket_pkg::*;

  logic c = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 c = ~c;

  bucket_decoder_if #(.ERR_CNT_W(8)) bus ();
  bucket_decoder_if #(.ERR_CNT_W(2)) bus2 ();
  fifo_state_e dbg, dbg2;

  bucket_decoder #(.DEPTH(2), .ERR_CNT_W(8)) dut (
    .c(c), .rst(rst), .bus(bus), .dbg_state(dbg)
  );

  bucket_decoder #(.DEPTH(2), .ERR_CNT_W(2)) dut_sat (
    .c(c), .rst(rst2), .bus(bus2), .dbg_state(dbg2)
  );

  int checks = 0;
  int failures = 0;
  logic [20:0] exp_q[$];

  typedef struct {
    logic [3:0] code;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       err;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] model(input logic [3:0] code);
    int lo = 0;
    int hi = 0;
    logic e = 1'b0;
    if (code == 4'd0) begin
      lo = 0; hi = 0;
    end else if (code == 4'd1) begin
      lo = 1; hi = 3;
    end else if (code <= 4'd9) begin
      lo = 1 << code;
      hi = (2 << code) - 1;
    end else begin
      e = 1'b1;
    end
    return {e, hi[9:0], lo[9:0]};
  endfunction

  // Scoreboard: push on accept, pop-and-compare on every DUT pop.
  always @(negedge c) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got pop with lo=%0d expected no entry", bus.out_lo);
        end else begin
          check("sb_head", {11'd0, bus.out_err, bus.out_hi, bus.out_lo}, {11'd0, exp_q.pop_front()});
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_code));
    end
  end

  // Holds in_valid until an accept edge; returns at posedge+1 after it.
  task automatic send(input logic [3:0] code);
    bit done = 1'b0;
    bus.in_code  = code;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge c);
      if (bus.in_ready) done = 1'b1;
      @(posedge c);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for code %0d expected accept within 50 cycles", code);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'd0,  10'd0,   10'd0,    1'b0};
    vecs[1]  = '{4'd1,  10'd1,   10'd3,    1'b0};
    vecs[2]  = '{4'd2,  10'd4,   10'd7,    1'b0};
    vecs[3]  = '{4'd3,  10'd8,   10'd15,   1'b0};
    vecs[4]  = '{4'd4,  10'd16,  10'd31,   1'b0};
    vecs[5]  = '{4'd5,  10'd32,  10'd63,   1'b0};
    vecs[6]  = '{4'd6,  10'd64,  10'd127,  1'b0};
    vecs[7]  = '{4'd7,  10'd128, 10'd255,  1'b0};
    vecs[8]  = '{4'd8,  10'd256, 10'd511,  1'b0};
    vecs[9]  = '{4'd9,  10'd512, 10'd1023, 1'b0};
    vecs[10] = '{4'd10, 10'd0,   10'd0,    1'b1};
    vecs[11] = '{4'd15, 10'd0,   10'd0,    1'b1};

    bus.in_valid   = 1'b0;
    bus.in_code    = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_code   = '0;
    bus2.out_ready = 1'b1;

    // Reset
    rst = 1'b1;
    @(posedge c);
    @(negedge c);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(posedge c); #1;
    rst = 1'b0;
    @(negedge c);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_err_count", bus.err_count, 0);
    check("post_rst_lo", bus.out_lo, 0);
    check("post_rst_hi", bus.out_hi, 0);
    check("post_rst_state", 32'(dbg), 32'(FIFO_EMPTY));
    @(posedge c); #1;

    // Decode table sweep, one cycle accept-to-output
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].code);
      @(negedge c);
      check("vec_valid", bus.out_valid, 1);
      check("vec_lo", bus.out_lo, vecs[i].lo);
      check("vec_hi", bus.out_hi, vecs[i].hi);
      check("vec_err", bus.out_err, vecs[i].err);
      @(posedge c); #1;
    end
    @(negedge c);
    check("illegal_err_count", bus.err_count, 2);
    check("sweep_drained_valid", bus.out_valid, 0);
    @(posedge c); #1;

    // Backpressure: fill, hold, release without full-bypass
    bus.out_ready = 1'b0;
    send(4'd2);
    send(4'd4);
    bus.in_code  = 4'd6;
    bus.in_valid = 1'b1;
    @(negedge c);
    check("bp_full_in_ready", bus.in_ready, 0);
    check("bp_full_state", 32'(dbg), 32'(FIFO_FULL));
    check("bp_head_lo", bus.out_lo, 4);
    @(posedge c);
    @(negedge c);
    check("bp_hold_in_ready", bus.in_ready, 0);
    check("bp_hold_lo", bus.out_lo, 4);
    check("bp_hold_hi", bus.out_hi, 7);
    @(posedge c); #1;
    bus.out_ready = 1'b1;
    check("bp_no_bypass", bus.in_ready, 0);
    @(posedge c);
    @(negedge c);
    check("bp_second_lo", bus.out_lo, 16);
    check("bp_reopen_in_ready", bus.in_ready, 1);
    @(posedge c); #1;
    bus.in_valid = 1'b0;
    @(negedge c);
    check("bp_late_lo", bus.out_lo, 64);
    @(posedge c); #1;

    // Simultaneous push/pop at count 1
    bus.out_ready = 1'b0;
    send(4'd3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_code  = 4'($urandom_range(0, 9));
      bus.in_valid = 1'b1;
      @(negedge c);
      check("pp_in_ready", bus.in_ready, 1);
      check("pp_state", 32'(dbg), 32'(FIFO_PARTIAL));
      @(posedge c); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge c);
    check("pp_end_state", 32'(dbg), 32'(FIFO_PARTIAL));
    @(posedge c); #1;
    @(negedge c);
    check("pp_drained_state", 32'(dbg), 32'(FIFO_EMPTY));
    @(posedge c); #1;

    // Reset with two queued entries
    bus.out_ready = 1'b0;
    send(4'd10);
    send(4'd5);
    @(negedge c);
    check("pre_rst_err_count", bus.err_count, 3);
    check("pre_rst_state", 32'(dbg), 32'(FIFO_FULL));
    @(posedge c); #1;
    rst = 1'b1;
    @(negedge c);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge c); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge c);
    check("after_rst_out_valid", bus.out_valid, 0);
    check("after_rst_err_count", bus.err_count, 0);
    check("after_rst_state", 32'(dbg), 32'(FIFO_EMPTY));
    @(posedge c); #1;
    send(4'd7);
    @(negedge c);
    check("first_after_rst_lo", bus.out_lo, 128);
    check("first_after_rst_hi", bus.out_hi, 255);
    @(posedge c); #1;
    @(negedge c);
    check("final_out_valid", bus.out_valid, 0);
    check("sb_drained", exp_q.size(), 0);
    @(posedge c); #1;

    // Saturating error counter with a 2-bit width
    rst2 = 1'b1;
    @(posedge c);
    @(posedge c); #1;
    rst2 = 1'b0;
    bus2.in_code  = 4'd11;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge c);
      check("sat_in_ready", bus2.in_ready, 1);
      check("sat_err_count", bus2.err_count, (i < 3) ? i : 3);
      @(posedge c); #1;
    end
    bus2.in_valid = 1'b0;
    @(negedge c);
    check("sat_final_err_count", bus2.err_count, 3);
    check("sat_head_err", bus2.out_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
